// File: rtl/logic_gate_pipe.sv
// Two-stage pipelined bitwise gate unit: eight logic ops on WIDTH-bit operands,
// registered result with zero/ones/parity flags and a consumed-transaction counter.
module logic_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_zero,
    output logic             flag_ones,
    output logic             flag_parity,
    output logic [CNT_W-1:0] txn_count
);

    // Handshake: a beat transfers on any rising edge where valid && ready are both
    // high; valid never depends on ready, and a stalled output holds its payload.
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [2:0]       s1_op;
    logic             s1_adv;
    logic             accept;
    logic             consume;
    logic [WIDTH-1:0] res;

    assign s1_adv   = s1_valid && (!out_valid || out_ready);
    assign in_ready = !s1_valid || !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_comb begin
        res = '0;
        case (s1_op)
            3'd0: res = s1_a & s1_b;
            3'd1: res = s1_a | s1_b;
            3'd2: res = ~(s1_a & s1_b);
            3'd3: res = ~(s1_a | s1_b);
            3'd4: res = s1_a ^ s1_b;
            3'd5: res = ~(s1_a ^ s1_b);
            3'd6: res = ~s1_a;
            3'd7: res = s1_a;
        endcase
    end

    // Stage 1: operand capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_op    <= '0;
        end else if (accept) begin
            s1_valid <= 1'b1;
            s1_a     <= a;
            s1_b     <= b;
            s1_op    <= op;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Stage 2: flags are derived from the new result so they line up with y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            y           <= '0;
            flag_zero   <= 1'b0;
            flag_ones   <= 1'b0;
            flag_parity <= 1'b0;
        end else if (s1_adv) begin
            out_valid   <= 1'b1;
            y           <= res;
            flag_zero   <= ~|res;
            flag_ones   <= &res;
            flag_parity <= ^res;
        end else if (consume) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
        end else if (consume) begin
            txn_count <= txn_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Directed bench for logic_gate_pipe: a 1-bit instance for the gate truth tables
// and an 8-bit instance with a 4-bit counter for streaming, stall, wrap and reset.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // 1-bit instance
    logic        d1_in_valid, d1_in_ready, d1_a, d1_b, d1_out_valid, d1_out_ready, d1_y;
    logic [2:0]  d1_op;
    logic        d1_zero, d1_ones, d1_par;
    logic [15:0] d1_cnt;

    // 8-bit instance, 4-bit counter
    logic       d8_in_valid, d8_in_ready, d8_out_valid, d8_out_ready;
    logic [7:0] d8_a, d8_b, d8_y;
    logic [2:0] d8_op;
    logic       d8_zero, d8_ones, d8_par;
    logic [3:0] d8_cnt;

    logic_gate_pipe #(.WIDTH(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(d1_in_valid), .in_ready(d1_in_ready),
        .a(d1_a), .b(d1_b), .op(d1_op), .out_valid(d1_out_valid), .out_ready(d1_out_ready),
        .y(d1_y), .flag_zero(d1_zero), .flag_ones(d1_ones), .flag_parity(d1_par),
        .txn_count(d1_cnt)
    );

    logic_gate_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(d8_in_valid), .in_ready(d8_in_ready),
        .a(d8_a), .b(d8_b), .op(d8_op), .out_valid(d8_out_valid), .out_ready(d8_out_ready),
        .y(d8_y), .flag_zero(d8_zero), .flag_ones(d8_ones), .flag_parity(d8_par),
        .txn_count(d8_cnt)
    );

    typedef struct {
        logic       a;
        logic       b;
        logic [2:0] op;
        logic       y;
    } vec1_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic [7:0] y;
        logic       z;
        logic       o;
        logic       p;
    } vec8_t;

    vec1_t v1[24];
    vec8_t v8[11];
    logic [3:0] y_tab[6];
    logic [10:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec8_t mk8(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                                  input logic [7:0] y, input logic z, input logic o, input logic p);
        vec8_t v;
        v.a = a; v.b = b; v.op = op; v.y = y; v.z = z; v.o = o; v.p = p;
        return v;
    endfunction

    function automatic logic [10:0] pack_exp(input logic [7:0] y);
        return {y, (y == 8'h00), (y == 8'hFF), ^y};
    endfunction

    // Scoreboard: every consumed 8-bit result must match the head of exp_q
    always @(negedge clk) begin
        if (rst_n && d8_out_valid && d8_out_ready) begin
            if (exp_q.size() == 0) begin
                check("d8_unexpected_out", 32'(d8_y), 32'hDEAD);
            end else begin
                check("d8_out", 32'({d8_y, d8_zero, d8_ones, d8_par}), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        // truth tables indexed by {a,b}
        y_tab[0] = 4'b1000; // AND
        y_tab[1] = 4'b1110; // OR
        y_tab[2] = 4'b0111; // NAND
        y_tab[3] = 4'b0001; // NOR
        y_tab[4] = 4'b0110; // XOR
        y_tab[5] = 4'b1001; // XNOR
        for (int o = 0; o < 6; o++) begin
            for (int ab = 0; ab < 4; ab++) begin
                v1[o*4+ab].a  = ab[1];
                v1[o*4+ab].b  = ab[0];
                v1[o*4+ab].op = 3'(o);
                v1[o*4+ab].y  = y_tab[o][ab];
            end
        end
        v8[0]  = mk8(8'hF0, 8'h3C, 3'd0, 8'h30, 1'b0, 1'b0, 1'b0);
        v8[1]  = mk8(8'hF0, 8'h3C, 3'd1, 8'hFC, 1'b0, 1'b0, 1'b0);
        v8[2]  = mk8(8'hF0, 8'h3C, 3'd2, 8'hCF, 1'b0, 1'b0, 1'b0);
        v8[3]  = mk8(8'hF0, 8'h3C, 3'd3, 8'h03, 1'b0, 1'b0, 1'b0);
        v8[4]  = mk8(8'hF0, 8'h3C, 3'd4, 8'hCC, 1'b0, 1'b0, 1'b0);
        v8[5]  = mk8(8'hF0, 8'h3C, 3'd5, 8'h33, 1'b0, 1'b0, 1'b0);
        v8[6]  = mk8(8'hF0, 8'h3C, 3'd6, 8'h0F, 1'b0, 1'b0, 1'b0);
        v8[7]  = mk8(8'hF0, 8'h3C, 3'd7, 8'hF0, 1'b0, 1'b0, 1'b0);
        v8[8]  = mk8(8'h00, 8'h00, 3'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        v8[9]  = mk8(8'h00, 8'h00, 3'd3, 8'hFF, 1'b0, 1'b1, 1'b0);
        v8[10] = mk8(8'h01, 8'h5A, 3'd7, 8'h01, 1'b0, 1'b0, 1'b1);

        // ---- reset state ----
        rst_n = 1'b0;
        d1_in_valid = 0; d1_a = 0; d1_b = 0; d1_op = 0; d1_out_ready = 1;
        d8_in_valid = 0; d8_a = 0; d8_b = 0; d8_op = 0; d8_out_ready = 1;
        #12;
        check("rst_out_valid", 32'(d8_out_valid), 32'd0);
        check("rst_y", 32'(d8_y), 32'd0);
        check("rst_flags", 32'({d8_zero, d8_ones, d8_par}), 32'd0);
        check("rst_count", 32'(d8_cnt), 32'd0);
        check("rst_in_ready", 32'(d8_in_ready), 32'd1);
        check("rst_d1_y", 32'({d1_out_valid, d1_y, d1_zero, d1_ones, d1_par}), 32'd0);
        rst_n = 1'b1;
        tick();

        // ---- WIDTH=1 truth tables, two-edge latency ----
        for (int i = 0; i < 24; i++) begin
            d1_a = v1[i].a; d1_b = v1[i].b; d1_op = v1[i].op; d1_in_valid = 1'b1;
            check("d1_in_ready", 32'(d1_in_ready), 32'd1);
            tick();
            d1_in_valid = 1'b0;
            check("d1_not_yet", 32'(d1_out_valid), 32'd0);
            tick();
            check("d1_valid", 32'(d1_out_valid), 32'd1);
            check("d1_y", 32'({d1_y, d1_zero, d1_ones, d1_par}),
                  32'({v1[i].y, ~v1[i].y, v1[i].y, v1[i].y}));
            tick();
        end
        check("d1_count", 32'(d1_cnt), 32'd24);

        // ---- WIDTH=8 back-to-back stream ----
        for (int i = 0; i < 8; i++) begin
            d8_a = v8[i].a; d8_b = v8[i].b; d8_op = v8[i].op; d8_in_valid = 1'b1;
            exp_q.push_back({v8[i].y, v8[i].z, v8[i].o, v8[i].p});
            check("stream_in_ready", 32'(d8_in_ready), 32'd1);
            tick();
        end
        d8_in_valid = 1'b0;
        tick();
        tick();
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        check("stream_idle", 32'(d8_out_valid), 32'd0);
        check("stream_count", 32'(d8_cnt), 32'd8);

        // ---- flag vectors ----
        for (int i = 8; i < 11; i++) begin
            d8_a = v8[i].a; d8_b = v8[i].b; d8_op = v8[i].op; d8_in_valid = 1'b1;
            exp_q.push_back({v8[i].y, v8[i].z, v8[i].o, v8[i].p});
            tick();
        end
        d8_in_valid = 1'b0;
        tick();
        tick();
        check("flags_drained", 32'(exp_q.size()), 32'd0);
        check("flags_count", 32'(d8_cnt), 32'd11);

        // ---- backpressure ----
        d8_out_ready = 1'b0;
        d8_a = 8'hAA; d8_b = 8'h0F; d8_op = 3'd4; d8_in_valid = 1'b1;
        exp_q.push_back(pack_exp(8'hA5));
        tick();
        d8_op = 3'd0;
        exp_q.push_back(pack_exp(8'h0A));
        tick();
        d8_op = 3'd3;
        exp_q.push_back(pack_exp(8'h50));
        check("bp_full_in_ready", 32'(d8_in_ready), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_in_ready", 32'(d8_in_ready), 32'd0);
            check("bp_hold", 32'({d8_out_valid, d8_y, d8_zero, d8_ones, d8_par}),
                  32'({1'b1, 8'hA5, 3'b000}));
        end
        d8_out_ready = 1'b1;
        #1;
        check("bp_release_ready", 32'(d8_in_ready), 32'd1);
        tick();
        d8_in_valid = 1'b0;
        check("bp_gap1", 32'({d8_out_valid, d8_y}), 32'({1'b1, 8'h0A}));
        tick();
        check("bp_gap2", 32'({d8_out_valid, d8_y}), 32'({1'b1, 8'h50}));
        tick();
        check("bp_done", 32'(d8_out_valid), 32'd0);
        check("bp_drained", 32'(exp_q.size()), 32'd0);
        check("bp_count", 32'(d8_cnt), 32'd14);

        // ---- counter wrap on 4-bit counter ----
        #2 rst_n = 1'b0;
        exp_q.delete();
        #2 rst_n = 1'b1;
        for (int t = 1; t <= 19; t++) begin
            if (t <= 17) begin
                d8_a = 8'(t); d8_b = 8'h00; d8_op = 3'd7; d8_in_valid = 1'b1;
                exp_q.push_back(pack_exp(8'(t)));
            end else begin
                d8_in_valid = 1'b0;
            end
            tick();
            check("wrap_count", 32'(d8_cnt), 32'((t < 3) ? 0 : (t - 2) % 16));
        end
        check("wrap_drained", 32'(exp_q.size()), 32'd0);

        // ---- asynchronous reset with both stages full ----
        d8_out_ready = 1'b0;
        d8_a = 8'h3C; d8_b = 8'hC3; d8_op = 3'd1; d8_in_valid = 1'b1;
        exp_q.push_back(pack_exp(8'hFF));
        tick();
        exp_q.push_back(pack_exp(8'hFF));
        tick();
        d8_in_valid = 1'b0;
        check("full_before_rst", 32'({d8_out_valid, d8_in_ready}), 32'({1'b1, 1'b0}));
        #3 rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(d8_out_valid), 32'd0);
        check("mid_rst_y", 32'({d8_y, d8_zero, d8_ones, d8_par}), 32'd0);
        check("mid_rst_count", 32'(d8_cnt), 32'd0);
        exp_q.delete();
        #2 rst_n = 1'b1;
        d8_out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(d8_in_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("post_rst_no_stale", 32'(d8_out_valid), 32'd0);
        end
        check("post_rst_count", 32'(d8_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
